stream_buffer: RTL

STREAM_BUFFER -- requirements
Module: stream_buffer

---
 rtl/stream_buffer_pkg.sv | 11 +
 rtl/stream_buffer.sv | 99 +++++++++
 2 files changed

// File: rtl/stream_buffer_pkg.sv
// Shared types for the stream buffer: encodes the per-cycle handshake outcome.
package stream_buffer_pkg;

   typedef enum logic [1:0] {
      OpIdle = 2'b00,
      OpPush = 2'b01,
      OpPop  = 2'b10,
      OpBoth = 2'b11
   } op_e;

endpackage

// File: rtl/stream_buffer.sv
// Valid/ready FIFO of Depth entries; pushed data visible one cycle later (no fall-through).
// ready_o depends only on fill level, flush and reset; never combinationally on ready_i.
module stream_buffer
   import stream_buffer_pkg::*;
#(
   parameter type         data_t   = logic,
   parameter int unsigned Depth    = 4,
   localparam int unsigned PtrWidth = (Depth > 1) ? $clog2(Depth) : 1,
   localparam int unsigned CntWidth = $clog2(Depth + 1)
) (
   input  logic                clk_i,
   input  logic                rst_ni,
   input  logic                flush_i,
   input  data_t               data_i,
   input  logic                valid_i,
   output logic                ready_o,
   output data_t               data_o,
   output logic                valid_o,
   input  logic                ready_i,
   output logic [CntWidth-1:0] usage_o
);

   // Storage is rounded up to a power of two so pointers index it without width casts;
   // entries at Depth and above are never written or read.
   localparam int unsigned         MemDepth = 1 << PtrWidth;
   localparam logic [PtrWidth-1:0] LastPtr  = PtrWidth'(Depth - 1);
   localparam logic [CntWidth-1:0] FullCnt  = CntWidth'(Depth);

   data_t               mem_q [MemDepth];
   logic [PtrWidth-1:0] rd_ptr_q, rd_ptr_d;
   logic [PtrWidth-1:0] wr_ptr_q, wr_ptr_d;
   logic [CntWidth-1:0] usage_q, usage_d;
   logic                push, pop;
   op_e                 op;

   function automatic logic [PtrWidth-1:0] ptr_inc(input logic [PtrWidth-1:0] p);
      return (p == LastPtr) ? '0 : p + 1'b1;
   endfunction

   assign ready_o = (usage_q != FullCnt) && !flush_i && rst_ni;
   assign valid_o = (usage_q != '0) && !flush_i && rst_ni;
   assign push    = valid_i && ready_o;
   assign pop     = valid_o && ready_i;
   assign op      = op_e'({pop, push});
   assign data_o  = mem_q[rd_ptr_q];
   assign usage_o = usage_q;

   always_comb begin
      rd_ptr_d = rd_ptr_q;
      wr_ptr_d = wr_ptr_q;
      usage_d  = usage_q;
      if (flush_i) begin
         rd_ptr_d = '0;
         wr_ptr_d = '0;
         usage_d  = '0;
      end else begin
         case (op)
            OpPush: begin
               wr_ptr_d = ptr_inc(wr_ptr_q);
               usage_d  = usage_q + 1'b1;
            end
            OpPop: begin
               rd_ptr_d = ptr_inc(rd_ptr_q);
               usage_d  = usage_q - 1'b1;
            end
            OpBoth: begin
               wr_ptr_d = ptr_inc(wr_ptr_q);
               rd_ptr_d = ptr_inc(rd_ptr_q);
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         usage_q  <= '0;
      end else begin
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         usage_q  <= usage_d;
      end
   end

   // push is already gated by reset and flush through ready_o
   always_ff @(posedge clk_i) begin
      if (push) begin
         mem_q[wr_ptr_q] <= data_i;
      end
   end

`ifndef SYNTHESIS
   upstream_stable_a : assert property (@(posedge clk_i) disable iff (!rst_ni)
      (valid_i && !ready_o && !flush_i) |=> (valid_i && $stable(data_i)));
`endif

endmodule
